regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32 core, the successor to the current 2-read/1-write file. Provides `NRD` combinational read ports, two write ports (port A from ALU writeback, port B from load/multicycle writeback) and optional same-cycle write-to-read bypass. A per-register busy scoreboard lets the decode stage detect RAW hazards on long-latency results. It sits between decode (reads, issue marking) and the two writeback paths.

---
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write ports, optional write-to-read bypass
// and a per-register busy scoreboard for long-latency RAW hazard detection.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [CW-1:0]       busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic wa_we, wb_we, iss_ok;
    logic set_new, clr_old;

    // Address 0 is read-only and never tracked when it is the hardwired zero register.
    assign wa_we  = wa_en  && !((ZERO_REG != 0) && (wa_addr  == '0));
    assign wb_we  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == '0));
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // Population count moves by at most one per edge; a set on the register being
    // cleared in the same cycle wins, so that clear does not count.
    assign set_new = iss_ok && !busy[iss_addr];
    assign clr_old = wb_en && busy[wb_addr] && !(iss_ok && (iss_addr == wb_addr));

    always_comb begin
        busy_nxt = busy;
        if (wb_en)
            busy_nxt[wb_addr] = 1'b0;
        if (iss_ok)
            busy_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset on purpose: reads must return zero during and after reset.
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // NOTE: with non-blocking assignments the last one in program order wins,
            // so port A is written after port B to give it priority on a collision.
            if (wb_we)
                regs[wb_addr] <= wb_data;
            if (wa_we)
                regs[wa_addr] <= wa_data;
            busy <= busy_nxt;
            if (set_new && !clr_old)
                busy_cnt <= busy_cnt + CW'(1);
            else if (clr_old && !set_new)
                busy_cnt <= busy_cnt - CW'(1);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]   a;
            logic [XLEN-1:0] val;
            logic            bsy;
            a   = rd_addr[i*AW +: AW];
            val = regs[a];
            bsy = busy[a];
            if ((BYPASS != 0) && rst_n) begin
                if (wa_en && (wa_addr == a))
                    val = wa_data;
                else if (wb_en && (wb_addr == a))
                    val = wb_data;
                if (wb_en && (wb_addr == a))
                    bsy = 1'b0;
            end
            if (!rst_n || ((ZERO_REG != 0) && (a == '0))) begin
                val = '0;
                bsy = 1'b0;
            end
            rd_data[i*XLEN +: XLEN] = val;
            rd_busy[i]              = bsy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: bypassing and non-bypassing instances driven from the same
// stimulus, table vectors checked through an expectation queue, plus hand sequences.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data, rd_data_nb;
    logic [1:0]        rd_busy, rd_busy_nb;
    logic              wa_en, wb_en, iss_en;
    logic [AW-1:0]     wa_addr, wb_addr, iss_addr;
    logic [XLEN-1:0]   wa_data, wb_data;
    logic [CW-1:0]     busy_cnt, busy_cnt_nb;

    int checks   = 0;
    int failures = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt_nb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            wa_en;
        logic [AW-1:0]   wa_addr;
        logic [XLEN-1:0] wa_data;
        logic            wb_en;
        logic [AW-1:0]   wb_addr;
        logic [XLEN-1:0] wb_data;
        logic            iss_en;
        logic [AW-1:0]   iss_addr;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] e_d0;
        logic [XLEN-1:0] e_d1;
        logic [1:0]      e_busy;
        logic [CW-1:0]   e_cnt;
        logic [XLEN-1:0] e_nb0;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic drive(input vec_t v);
        wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data;
        wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
        iss_en = v.iss_en; iss_addr = v.iss_addr;
        rd_addr = {v.ra1, v.ra0};
        exp_q.push_back(v);
    endtask

    task automatic sample(input int row);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL row%0d: no expectation queued", row);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("row%0d d0", row), rd_data[31:0], e.e_d0);
        check($sformatf("row%0d d1", row), rd_data[63:32], e.e_d1);
        check($sformatf("row%0d busy", row), 32'(rd_busy), 32'(e.e_busy));
        check($sformatf("row%0d cnt", row), 32'(busy_cnt), 32'(e.e_cnt));
        check($sformatf("row%0d nb_d0", row), rd_data_nb[31:0], e.e_nb0);
        check($sformatf("row%0d nb_cnt", row), 32'(busy_cnt_nb), 32'(e.e_cnt));
    endtask

    initial begin
        //           wa_en addr data          wb_en addr data          iss addr ra0 ra1  e_d0          e_d1          busy   cnt e_nb0
        vecs[0]  = '{1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, 2'b00, 6'd0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd7, 5'd0, 32'h1234_5678, 32'h0,         2'b00, 6'd0, 32'h1234_5678};
        vecs[2]  = '{1'b1, 5'd9, 32'h1111,      1'b1, 5'd9, 32'h2222,   1'b0, 5'd0, 5'd9, 5'd9, 32'h1111,      32'h1111,      2'b00, 6'd0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd9, 5'd7, 32'h1111,      32'h1234_5678, 2'b00, 6'd0, 32'h1111};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 32'h2222,   1'b1, 5'd3, 5'd9, 5'd3, 32'h2222,      32'h0,         2'b00, 6'd0, 32'h1111};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,      1'b1, 5'd4, 5'd3, 5'd4, 32'h0,         32'h0,         2'b01, 6'd1, 32'h0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 32'hBEEF,   1'b0, 5'd0, 5'd3, 5'd4, 32'hBEEF,      32'h0,         2'b10, 6'd2, 32'h0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd4, 32'h4444,   1'b1, 5'd4, 5'd4, 5'd3, 32'h4444,      32'hBEEF,      2'b00, 6'd1, 32'h0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd4, 5'd3, 32'h4444,      32'hBEEF,      2'b01, 6'd1, 32'h4444};
        vecs[9]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,      1'b1, 5'd0, 5'd0, 5'd4, 32'h0,         32'h4444,      2'b10, 6'd1, 32'h0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00, 6'd1, 32'h0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 32'h3333,   1'b1, 5'd4, 5'd3, 5'd4, 32'h3333,      32'h4444,      2'b10, 6'd1, 32'hBEEF};
        vecs[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd3, 5'd4, 32'h3333,      32'h4444,      2'b10, 6'd1, 32'h3333};
        vecs[13] = '{1'b1, 5'd4, 32'h6666,      1'b1, 5'd4, 32'h5555,   1'b1, 5'd6, 5'd4, 5'd5, 32'h6666,      32'h0,         2'b00, 6'd1, 32'h4444};
        vecs[14] = '{1'b1, 5'd6, 32'h7777,      1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd4, 5'd6, 32'h6666,      32'h7777,      2'b10, 6'd1, 32'h6666};
        vecs[15] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 5'd6, 5'd4, 32'h7777,      32'h6666,      2'b01, 6'd1, 32'h7777};

        // Reset from time zero, with a live port-A write aimed at the read address.
        rst_n = 1'b0;
        idle_inputs();
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hCAFE_F00D;
        rd_addr = {5'd7, 5'd7};
        #2;
        check("rst d0", rd_data[31:0], 32'h0);
        check("rst d1", rd_data[63:32], 32'h0);
        check("rst busy", 32'(rd_busy), 32'h0);
        check("rst cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst hold d0", rd_data[31:0], 32'h0);

        // Fill regs 1..31 and mark 1..10 busy, then reset mid-cycle.
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wa_en = 1'b1; wa_addr = AW'(i); wa_data = 32'hA5A5_0000 + 32'(i);
            iss_en = (i <= 10); iss_addr = AW'(i);
            @(negedge clk);
        end
        idle_inputs();
        rd_addr = {5'd31, 5'd5};
        #2;
        check("fill d0", rd_data[31:0], 32'hA5A5_0005);
        check("fill d1", rd_data[63:32], 32'hA5A5_001F);
        check("fill busy", 32'(rd_busy), 32'h1);
        check("fill cnt", 32'(busy_cnt), 32'd10);
        wa_en = 1'b1; wa_addr = 5'd31; wa_data = 32'hDEAD_0000;
        #1 rst_n = 1'b0;
        #1;
        check("midrst d0", rd_data[31:0], 32'h0);
        check("midrst d1", rd_data[63:32], 32'h0);
        check("midrst busy", 32'(rd_busy), 32'h0);
        check("midrst cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        rd_addr = {5'd1, 5'd5};
        #2;
        check("post rst d0", rd_data[31:0], 32'h0);
        check("post rst d1", rd_data[63:32], 32'h0);
        check("post rst busy", 32'(rd_busy), 32'h0);

        // Table vectors: each row's expectations are queued when it is driven.
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            drive(vecs[r]);
            #2;
            sample(r);
        end

        // Saturation: issue every register (x0 ignored, x6 already busy).
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            idle_inputs();
            iss_en = 1'b1; iss_addr = AW'(i);
        end
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd1, 5'd31};
        #2;
        check("sat cnt", 32'(busy_cnt), 32'd31);
        check("sat nb cnt", 32'(busy_cnt_nb), 32'd31);
        check("sat busy", 32'(rd_busy), 32'h3);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wb_en = 1'b1; wb_addr = AW'(i); wb_data = 32'(i);
        end
        @(negedge clk);
        idle_inputs();
        #2;
        check("drain cnt", 32'(busy_cnt), 32'd0);
        check("drain d0", rd_data[31:0], 32'd31);
        check("drain nb d0", rd_data_nb[31:0], 32'd31);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h99;
        @(negedge clk);
        idle_inputs();
        #2;
        check("underflow cnt", 32'(busy_cnt), 32'd0);
        check("underflow d1", rd_data[63:32], 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
